transferencia_matriz: RTL and testbench
=======================================

# transferencia_matriz

DMA-style sequencer between the coprocessor datapath and `fluxo_ram`. On a single-cycle start it moves one square matrix (2×2 to 5×5, 9-bit elements, row-major) between a flat register bus and the RAM. In read mode it reads the matrix out of RAM and absorbs the RAM's registered read latency. In write mode it writes the matrix into RAM. It drives `fluxo_ram`'s `endereco`, `dado_entrada` and `grava`, and consumes its `dado_saida`.

## Interface
- `LATENCIA`, default 2: cycles from `endereco` presented to matching word valid on `dado_saida`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `inicio`, in, 1: start pulse; sampled only in OCIOSO.
- `modo`, in, 1: 0 = read RAM→bus, 1 = write bus→RAM; sampled with `inicio`.
- `base`, in, 8: RAM address of element (0,0); sampled with `inicio`.
- `tamanho`, in, 3: matrix order n, valid 2..5; sampled with `inicio`.
- `matriz_entrada`, in, 225: 25 slots × 9 bits; slot s = bits [9s+8:9s]; latched at `inicio`.
- `dado_saida`, in, 9: read data from `fluxo_ram`.
- `endereco`, out, 8: RAM address.
- `dado_entrada`, out, 9: RAM write data.
- `grava`, out, 1: RAM write enable.
- `matriz_saida`, out, 225: read result, same slot layout.
- `ocupado`, out, 1: transfer in progress.
- `pronto`, out, 1: one-cycle done pulse.
- `erro`, out, 1: valid with `pronto`; 1 = `tamanho` out of range.

## Operation
- States: OCIOSO, LEITURA, DRENO, ESCRITA, CONCLUIDO.
- OCIOSO with `inicio`=1:
  - If `tamanho` is outside 2..5: go to CONCLUIDO with `erro`=1. No RAM access.
  - Else if `modo`=0: go to LEITURA.
  - Else: go to ESCRITA.
- `inicio` outside OCIOSO is ignored.
- Element index k = 0..N−1 with N = n·n, row r = k / n, column c = k mod n.
- RAM address = `base` + k, computed in 8 bits; wraps 255→0.
- Bus slot = 5·r + c. The bus stride is fixed at 5, independent of n.
- LEITURA:
  - `matriz_saida` is cleared to 0 on entry.
  - One address per cycle, `grava`=0.
  - Each issued address pushes {valid, slot} into a LATENCIA-deep delay line.
  - When the delay line output is valid, `dado_saida` is written into that slot.
  - After k = N−1 is issued, go to DRENO.
- DRENO: no new addresses; leave when the delay line is empty.
- ESCRITA:
  - One element per cycle: `grava`=1, `endereco`=`base`+k, `dado_entrada` = latched slot 5r+c.
  - After k = N−1, go to CONCLUIDO.
- CONCLUIDO: `pronto`=1 for one cycle, then OCIOSO.
- `matriz_saida` holds its value until the next read starts. Write mode and error completions leave it unchanged.
- Reset mid-transfer:
  - Immediate return to OCIOSO.
  - In-flight reads are discarded.
  - No spurious `grava` pulse.

## Timing
- Reset values:
  - `endereco`=0, `dado_entrada`=0, `grava`=0.
  - `matriz_saida`=0.
  - `ocupado`=0, `pronto`=0, `erro`=0.
  - State OCIOSO; delay line empty.
- All outputs are registered.
- Cycle 0 is the cycle in which `inicio` is sampled. `ocupado`=1 from cycle 1 until the cycle after `pronto`.
- Read:
  - Address k is on `endereco` in cycle 1+k.
  - Its data is captured at the end of cycle 1+k+LATENCIA.
  - `pronto` is in cycle N+LATENCIA+1.
- Write:
  - `grava`=1 in cycles 1..N.
  - `pronto` is in cycle N+1.
- Error: `pronto`=`erro`=1 in cycle 1.
- Idle outputs: `grava`=0 and `dado_entrada`=0 whenever not in ESCRITA; `endereco` returns to 0 in OCIOSO.
- A new `inicio` is accepted in the cycle after `pronto`.

## Structure
- Shared package `pacote_coprocessador`:
  - DIM_MAX=5, LARG_DADO=9, LARG_END=8.
  - State encoding constants.
  - Slot index width: 5 bits.
- Sub-module `linha_atraso_valido`: a parameterised shift register of {valid, slot}, depth LATENCIA, with async active-low clear.

## Test plan
- Write, n=3, `base`=0x10, slots 0..2, 5..7, 10..12 = 1..9:
  - `grava` high 9 cycles at addresses 0x10..0x18 with data 1..9.
  - `pronto` in cycle 10.
- Read back the same matrix using a `fluxo_ram` model with LATENCIA=2:
  - `matriz_saida` slots 0..2, 5..7, 10..12 = 1..9; all other slots 0.
  - `pronto` in cycle 12.
- n=5, `base`=0xF0, write then read:
  - Addresses wrap 0xF0..0xFF, 0x00..0x08.
  - All 25 slots match, including 9-bit value 0x1FF.
- `tamanho`=6, then `tamanho`=1:
  - `pronto` and `erro` high in cycle 1.
  - `grava` never asserted; `matriz_saida` unchanged.
- `inicio` pulsed again mid-read, then `rst_n` low at cycle 5 of a 5×5 write:
  - Second `inicio` ignored.
  - After reset, all outputs are at reset values; no further `grava`.
  - The next `inicio` completes normally.

Source files
------------

// File: rtl/pacote_coprocessador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pacote_coprocessador: shared widths, FSM encoding and slot helpers    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pacote_coprocessador;

  localparam int DIM_MAX     = 5;
  localparam int LARG_DADO   = 9;
  localparam int LARG_END    = 8;
  localparam int LARG_SLOT   = 5;
  localparam int LARG_DIM    = 3;
  localparam int NUM_SLOTS   = DIM_MAX * DIM_MAX;
  localparam int LARG_MATRIZ = NUM_SLOTS * LARG_DADO;
  localparam int LARG_IDX    = $clog2(LARG_MATRIZ);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    LEITURA   = 3'd1,
    DRENO     = 3'd2,
    ESCRITA   = 3'd3,
    CONCLUIDO = 3'd4
  } estado_t;

  // Bus slot uses a fixed stride of DIM_MAX regardless of the matrix order.
  function automatic logic [LARG_SLOT-1:0] slot_de(input logic [LARG_DIM-1:0] lin,
                                                   input logic [LARG_DIM-1:0] col);
    return LARG_SLOT'(lin) * LARG_SLOT'(DIM_MAX) + LARG_SLOT'(col);
  endfunction

  function automatic logic [LARG_IDX-1:0] bit_do_slot(input logic [LARG_SLOT-1:0] slot);
    return LARG_IDX'(slot) * LARG_IDX'(LARG_DADO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/linha_atraso_valido.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linha_atraso_valido: {valid, slot} shift register tracking reads      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module linha_atraso_valido
  import pacote_coprocessador::*;
#(
  parameter int PROFUNDIDADE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entrada_valido,
  input  logic [LARG_SLOT-1:0] entrada_slot,
  output logic                 saida_valido,
  output logic [LARG_SLOT-1:0] saida_slot,
  output logic                 pendente
);

  logic [PROFUNDIDADE-1:0]                valido_q, valido_d;
  logic [PROFUNDIDADE-1:0][LARG_SLOT-1:0] slot_q, slot_d;

  always_comb begin
    valido_d    = valido_q;
    slot_d      = slot_q;
    valido_d[0] = entrada_valido;
    slot_d[0]   = entrada_slot;
    for (int i = 1; i < PROFUNDIDADE; i++) begin
      valido_d[i] = valido_q[i-1];
      slot_d[i]   = slot_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valido_q <= '0;
      slot_q   <= '0;
    end else begin
      valido_q <= valido_d;
      slot_q   <= slot_d;
    end
  end

  assign saida_valido = valido_q[PROFUNDIDADE-1];
  assign saida_slot   = slot_q[PROFUNDIDADE-1];

  // Anything still travelling behind the output stage keeps the drain going.
  generate
    if (PROFUNDIDADE > 1) begin : g_pendente
      assign pendente = |valido_q[PROFUNDIDADE-2:0];
    end else begin : g_sem_pendente
      assign pendente = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/transferencia_matriz.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | transferencia_matriz: moves an n x n matrix between bus and fluxo_ram |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module transferencia_matriz
  import pacote_coprocessador::*;
#(
  parameter int LATENCIA = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic                   modo,
  input  logic [LARG_END-1:0]    base,
  input  logic [LARG_DIM-1:0]    tamanho,
  input  logic [LARG_MATRIZ-1:0] matriz_entrada,
  input  logic [LARG_DADO-1:0]   dado_saida,
  output logic [LARG_END-1:0]    endereco,
  output logic [LARG_DADO-1:0]   dado_entrada,
  output logic                   grava,
  output logic [LARG_MATRIZ-1:0] matriz_saida,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro
);

  estado_t                estado_q, estado_d;
  logic [LARG_DIM-1:0]    n_q, n_d;
  logic [LARG_DIM-1:0]    lin_q, lin_d;
  logic [LARG_DIM-1:0]    col_q, col_d;
  logic [LARG_MATRIZ-1:0] mat_lat_q, mat_lat_d;
  logic [LARG_MATRIZ-1:0] matriz_saida_q, matriz_saida_d;
  logic [LARG_END-1:0]    endereco_q, endereco_d;
  logic [LARG_DADO-1:0]   dado_entrada_q, dado_entrada_d;
  logic                   grava_q, grava_d;
  logic                   ocupado_q, ocupado_d;
  logic                   pronto_q, pronto_d;
  logic                   erro_q, erro_d;

  logic                   ultima_col;
  logic                   ultimo;
  logic [LARG_DIM-1:0]    col_prox;
  logic [LARG_DIM-1:0]    lin_prox;
  logic                   tamanho_ok;

  logic                   push_valido;
  logic [LARG_SLOT-1:0]   push_slot;
  logic                   sai_valido;
  logic [LARG_SLOT-1:0]   sai_slot;
  logic                   pendente;

  assign ultima_col = (col_q == n_q - 3'd1);
  assign ultimo     = ultima_col && (lin_q == n_q - 3'd1);
  assign col_prox   = ultima_col ? '0 : col_q + 3'd1;
  assign lin_prox   = ultima_col ? lin_q + 3'd1 : lin_q;
  assign tamanho_ok = (tamanho >= 3'd2) && (tamanho <= 3'(DIM_MAX));

  // The element on endereco this cycle enters the tracker; it pops out
  // exactly when fluxo_ram presents its word.
  assign push_valido = (estado_q == LEITURA);
  assign push_slot   = slot_de(lin_q, col_q);

  linha_atraso_valido #(
    .PROFUNDIDADE (LATENCIA)
  ) u_linha (
    .clk            (clk),
    .rst_n          (rst_n),
    .entrada_valido (push_valido),
    .entrada_slot   (push_slot),
    .saida_valido   (sai_valido),
    .saida_slot     (sai_slot),
    .pendente       (pendente)
  );

  always_comb begin
    estado_d       = estado_q;
    n_d            = n_q;
    lin_d          = lin_q;
    col_d          = col_q;
    mat_lat_d      = mat_lat_q;
    matriz_saida_d = matriz_saida_q;
    endereco_d     = '0;
    dado_entrada_d = '0;
    grava_d        = 1'b0;
    pronto_d       = 1'b0;
    erro_d         = 1'b0;

    if (sai_valido) begin
      matriz_saida_d[bit_do_slot(sai_slot) +: LARG_DADO] = dado_saida;
    end

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          n_d       = tamanho;
          lin_d     = '0;
          col_d     = '0;
          mat_lat_d = matriz_entrada;
          if (!tamanho_ok) begin
            estado_d = CONCLUIDO;
            pronto_d = 1'b1;
            erro_d   = 1'b1;
          end else if (!modo) begin
            estado_d       = LEITURA;
            endereco_d     = base;
            matriz_saida_d = '0;
          end else begin
            // First element comes straight off the bus; the latch is not loaded yet.
            estado_d       = ESCRITA;
            endereco_d     = base;
            grava_d        = 1'b1;
            dado_entrada_d = matriz_entrada[LARG_DADO-1:0];
          end
        end
      end

      LEITURA: begin
        if (ultimo) begin
          estado_d = DRENO;
        end else begin
          lin_d      = lin_prox;
          col_d      = col_prox;
          endereco_d = endereco_q + LARG_END'(1);
        end
      end

      DRENO: begin
        if (!pendente) begin
          estado_d = CONCLUIDO;
          pronto_d = 1'b1;
        end
      end

      ESCRITA: begin
        if (ultimo) begin
          estado_d = CONCLUIDO;
          pronto_d = 1'b1;
        end else begin
          lin_d          = lin_prox;
          col_d          = col_prox;
          endereco_d     = endereco_q + LARG_END'(1);
          grava_d        = 1'b1;
          dado_entrada_d = mat_lat_q[bit_do_slot(slot_de(lin_prox, col_prox)) +: LARG_DADO];
        end
      end

      CONCLUIDO: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= OCIOSO;
      n_q            <= '0;
      lin_q          <= '0;
      col_q          <= '0;
      mat_lat_q      <= '0;
      matriz_saida_q <= '0;
      endereco_q     <= '0;
      dado_entrada_q <= '0;
      grava_q        <= 1'b0;
      ocupado_q      <= 1'b0;
      pronto_q       <= 1'b0;
      erro_q         <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      n_q            <= n_d;
      lin_q          <= lin_d;
      col_q          <= col_d;
      mat_lat_q      <= mat_lat_d;
      matriz_saida_q <= matriz_saida_d;
      endereco_q     <= endereco_d;
      dado_entrada_q <= dado_entrada_d;
      grava_q        <= grava_d;
      ocupado_q      <= ocupado_d;
      pronto_q       <= pronto_d;
      erro_q         <= erro_d;
    end
  end

  assign endereco     = endereco_q;
  assign dado_entrada = dado_entrada_q;
  assign grava        = grava_q;
  assign matriz_saida = matriz_saida_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign erro         = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_transferencia_matriz.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_transferencia_matriz: directed bench with a fluxo_ram model        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_transferencia_matriz;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inicio = 1'b0;
  logic         modo = 1'b0;
  logic [7:0]   base = '0;
  logic [2:0]   tamanho = '0;
  logic [224:0] matriz_entrada = '0;
  logic [8:0]   dado_saida;
  logic [7:0]   endereco;
  logic [8:0]   dado_entrada;
  logic         grava;
  logic [224:0] matriz_saida;
  logic         ocupado;
  logic         pronto;
  logic         erro;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transferencia_matriz #(
    .LATENCIA (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inicio         (inicio),
    .modo           (modo),
    .base           (base),
    .tamanho        (tamanho),
    .matriz_entrada (matriz_entrada),
    .dado_saida     (dado_saida),
    .endereco       (endereco),
    .dado_entrada   (dado_entrada),
    .grava          (grava),
    .matriz_saida   (matriz_saida),
    .ocupado        (ocupado),
    .pronto         (pronto),
    .erro           (erro)
  );

  // fluxo_ram model: registered read, LAT cycles from address to data
  logic [8:0] mem  [256];
  logic [8:0] pipe [LAT];

  always @(posedge clk) begin
    if (grava) mem[endereco] <= dado_entrada;
    pipe[0] <= mem[endereco];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign dado_saida = pipe[LAT-1];

  task automatic verifica(input string tag, input logic [255:0] obs, input logic [255:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic confere_reset();
    verifica("rst_endereco", endereco, 0);
    verifica("rst_dado_entrada", dado_entrada, 0);
    verifica("rst_grava", grava, 0);
    verifica("rst_matriz_saida", matriz_saida, 0);
    verifica("rst_ocupado", ocupado, 0);
    verifica("rst_pronto", pronto, 0);
    verifica("rst_erro", erro, 0);
  endtask

  // One transfer: start in cycle 0, sample every cycle at negedge.
  task automatic executa(input logic m, input logic [7:0] b, input logic [2:0] t,
                         input logic [224:0] mat, input int ciclo_reinicio, input int ciclo_reset);
    int         n_el;
    int         esp_pronto;
    int         ng;
    int         s;
    bit         valido;
    bit         achou;
    logic [7:0] e_esp;
    logic [7:0] idx;
    valido     = (t >= 3'd2) && (t <= 3'd5);
    n_el       = int'(t) * int'(t);
    esp_pronto = !valido ? 1 : (m ? n_el + 1 : n_el + LAT + 1);
    ng         = 0;
    achou      = 1'b0;
    @(negedge clk);
    inicio = 1'b1; modo = m; base = b; tamanho = t; matriz_entrada = mat;
    for (int cyc = 1; cyc <= 80 && !achou; cyc++) begin
      @(posedge clk);
      #1;
      inicio = 1'b0; modo = 1'b0; base = '0; tamanho = '0; matriz_entrada = '0;
      @(negedge clk);
      if (cyc == 1) verifica("ocupado_c1", ocupado, 1);
      if (grava) begin
        e_esp = b + 8'(ng);
        s     = (t != 3'd0) ? 5 * (ng / int'(t)) + ng % int'(t) : 0;
        idx   = 8'(9 * s);
        verifica("grava_ciclo", cyc, ng + 1);
        verifica("grava_end", endereco, e_esp);
        verifica("grava_dado", dado_entrada, mat[idx +: 9]);
        ng++;
      end
      if (!m && valido && cyc <= n_el) begin
        e_esp = b + 8'(cyc - 1);
        verifica("leitura_end", endereco, e_esp);
      end
      if (cyc == ciclo_reinicio) begin
        inicio = 1'b1; modo = 1'b1; base = 8'hA0; tamanho = 3'd2; matriz_entrada = '1;
      end
      if (cyc == ciclo_reset) begin
        rst_n = 1'b0;
        #1;
        confere_reset();
        repeat (3) begin
          @(negedge clk);
          verifica("rst_sem_grava", grava, 0);
          verifica("rst_ocupado_baixo", ocupado, 0);
        end
        rst_n = 1'b1;
        return;
      end
      if (pronto) begin
        achou = 1'b1;
        verifica("pronto_ciclo", cyc, esp_pronto);
        verifica("erro", erro, !valido);
      end
    end
    if (!achou) begin
      verifica("timeout_pronto", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      @(negedge clk);
      verifica("ocupado_pos", ocupado, 0);
      verifica("pronto_pulso", pronto, 0);
      verifica("grava_ocioso", grava, 0);
      verifica("endereco_ocioso", endereco, 0);
    end
    verifica("num_grava", ng, (m && valido) ? n_el : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [224:0] m1;
    logic [224:0] m2;
    logic [7:0]   idx;
    int           slots3 [9];
    slots3 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    m1 = '0;
    for (int k = 0; k < 9; k++) begin
      idx = 8'(9 * slots3[k]);
      m1[idx +: 9] = 9'(k + 1);
    end
    m2 = '0;
    for (int s = 0; s < 25; s++) begin
      idx = 8'(9 * s);
      m2[idx +: 9] = 9'((s * 37 + 11) % 512);
    end
    m2[216 +: 9] = 9'h1FF;

    repeat (2) @(negedge clk);
    confere_reset();
    rst_n = 1'b1;

    executa(1'b1, 8'h10, 3'd3, m1, -1, -1);
    executa(1'b0, 8'h10, 3'd3, '0, -1, -1);
    verifica("leitura_3x3", matriz_saida, m1);

    executa(1'b1, 8'hF0, 3'd5, m2, -1, -1);
    executa(1'b0, 8'hF0, 3'd5, '0, -1, -1);
    verifica("leitura_5x5_wrap", matriz_saida, m2);

    executa(1'b1, 8'h30, 3'd6, m1, -1, -1);
    verifica("erro6_matriz", matriz_saida, m2);
    executa(1'b0, 8'h30, 3'd1, m1, -1, -1);
    verifica("erro1_matriz", matriz_saida, m2);

    executa(1'b0, 8'h10, 3'd3, '0, 3, -1);
    verifica("reinicio_ignorado", matriz_saida, m1);

    executa(1'b1, 8'h40, 3'd5, m2, -1, 5);
    executa(1'b0, 8'h10, 3'd3, '0, -1, -1);
    verifica("leitura_pos_reset", matriz_saida, m1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
